lut_decoder_seq: RTL and testbench

Iteration sequencer for the BKM FPU LUT decoder. It latches an operation's mode, format and iteration count, then steps the iteration index n from 0 to the last index. For each n it accepts the digit pair (d_x_n, d_y_n) from digit selection and drives the decoder inputs. It then registers the decoder's lut_X/lut_Y/lut_u/lut_v outputs and hands them downstream with a valid/ready handshake.

---
 rtl/lut_decoder_seq.sv | 201 ++++++++++++++++++++
 tb/tb_lut_decoder_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_decoder_seq.sv
// Iteration sequencer for the BKM FPU LUT decoder.
// Latches mode/format/n_last on start, then for each iteration index n accepts a digit
// pair, drives the decoder inputs for one LOOKUP cycle, registers the decoder outputs and
// holds them under a valid/ready handshake until consumed.
// Optional feature macro: LUT_SEQ_DIGIT_CHK_EN (illegal-digit check and sticky dig_err).
module lut_decoder_seq #(
  parameter int unsigned WD    = 64,
  parameter int unsigned WC    = 16,
  parameter int unsigned LOG2N = 6
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enable,
  input  logic              start,
  input  logic              mode,
  input  logic [1:0]        format,
  input  logic [LOG2N-1:0]  n_last,
  output logic              busy,
  output logic              done,
  input  logic [1:0]        d_x_n,
  input  logic [1:0]        d_y_n,
  input  logic              d_valid,
  output logic              d_ready,
  output logic              dec_mode,
  output logic [1:0]        dec_format,
  output logic [LOG2N-1:0]  dec_n,
  output logic [1:0]        dec_d_x_n,
  output logic [1:0]        dec_d_y_n,
  input  logic [2*WD-1:0]   lut_X_in,
  input  logic [2*WD-1:0]   lut_Y_in,
  input  logic [WC-1:0]     lut_u_in,
  input  logic [WC-1:0]     lut_v_in,
  output logic [2*WD-1:0]   lut_X_q,
  output logic [2*WD-1:0]   lut_Y_q,
  output logic [WC-1:0]     lut_u_q,
  output logic [WC-1:0]     lut_v_q,
  output logic [LOG2N-1:0]  lut_n_q,
  output logic              lut_last,
  output logic              lut_valid,
  input  logic              lut_ready,
  output logic              dig_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT_D = 3'd1;
  localparam logic [2:0] ST_LOOKUP = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic [LOG2N-1:0] n_last_q, n_last_d;
  logic             dec_mode_q, dec_mode_d;
  logic [1:0]       dec_format_q, dec_format_d;
  logic [1:0]       dec_dx_q, dec_dx_d;
  logic [1:0]       dec_dy_q, dec_dy_d;
  logic [2*WD-1:0]  lut_x_d, lut_y_d;
  logic [WC-1:0]    lut_u_d, lut_v_d;
  logic [LOG2N-1:0] lut_n_d;
  logic             lut_last_q, lut_last_d;
  logic [1:0]       d_x_clean, d_y_clean;

`ifdef LUT_SEQ_DIGIT_CHK_EN
  logic dig_err_q, dig_err_d;

  // Replace the illegal code 10 with 0 and flag it; the flag is cleared by a new start.
  always_comb begin
    d_x_clean = (d_x_n == 2'b10) ? 2'b00 : d_x_n;
    d_y_clean = (d_y_n == 2'b10) ? 2'b00 : d_y_n;
    dig_err_d = dig_err_q;
    if (state_q == ST_IDLE && start) begin
      dig_err_d = 1'b0;
    end else if (state_q == ST_WAIT_D && d_valid &&
                 (d_x_n == 2'b10 || d_y_n == 2'b10)) begin
      dig_err_d = 1'b1;
    end
  end

  // Sticky illegal-digit flag register.
  always_ff @(posedge clk) begin
    if (srst) begin
      dig_err_q <= 1'b0;
    end else if (enable) begin
      dig_err_q <= dig_err_d;
    end
  end

  assign dig_err = dig_err_q;
`else
  assign d_x_clean = d_x_n;
  assign d_y_clean = d_y_n;
  assign dig_err   = 1'b0;
`endif

  // Next-state logic for the sequencer FSM and its datapath registers.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    n_last_d     = n_last_q;
    dec_mode_d   = dec_mode_q;
    dec_format_d = dec_format_q;
    dec_dx_d     = dec_dx_q;
    dec_dy_d     = dec_dy_q;
    lut_x_d      = lut_X_q;
    lut_y_d      = lut_Y_q;
    lut_u_d      = lut_u_q;
    lut_v_d      = lut_v_q;
    lut_n_d      = lut_n_q;
    lut_last_d   = lut_last_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dec_mode_d   = mode;
          dec_format_d = format;
          n_last_d     = n_last;
          n_d          = '0;
          state_d      = ST_WAIT_D;
        end
      end
      ST_WAIT_D: begin
        if (d_valid) begin
          dec_dx_d = d_x_clean;
          dec_dy_d = d_y_clean;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // Decoder inputs have been stable all cycle; capture its outputs.
        lut_x_d    = lut_X_in;
        lut_y_d    = lut_Y_in;
        lut_u_d    = lut_u_in;
        lut_v_d    = lut_v_in;
        lut_n_d    = n_q;
        lut_last_d = (n_q == n_last_q);
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (lut_ready) begin
          if (lut_last_q) begin
            state_d = ST_DONE;
          end else begin
            // Only reached while n < n_last, so the counter cannot wrap.
            n_d     = n_q + LOG2N'(1);
            state_d = ST_WAIT_D;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers: srst wins over enable; enable low freezes everything.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      n_last_q     <= '0;
      dec_mode_q   <= 1'b0;
      dec_format_q <= '0;
      dec_dx_q     <= '0;
      dec_dy_q     <= '0;
      lut_X_q      <= '0;
      lut_Y_q      <= '0;
      lut_u_q      <= '0;
      lut_v_q      <= '0;
      lut_n_q      <= '0;
      lut_last_q   <= 1'b0;
    end else if (enable) begin
      state_q      <= state_d;
      n_q          <= n_d;
      n_last_q     <= n_last_d;
      dec_mode_q   <= dec_mode_d;
      dec_format_q <= dec_format_d;
      dec_dx_q     <= dec_dx_d;
      dec_dy_q     <= dec_dy_d;
      lut_X_q      <= lut_x_d;
      lut_Y_q      <= lut_y_d;
      lut_u_q      <= lut_u_d;
      lut_v_q      <= lut_v_d;
      lut_n_q      <= lut_n_d;
      lut_last_q   <= lut_last_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign d_ready    = (state_q == ST_WAIT_D);
  assign lut_valid  = (state_q == ST_HOLD);
  assign lut_last   = lut_last_q;
  assign dec_mode   = dec_mode_q;
  assign dec_format = dec_format_q;
  assign dec_n      = n_q;
  assign dec_d_x_n  = dec_dx_q;
  assign dec_d_y_n  = dec_dy_q;

endmodule

// File: tb/tb_lut_decoder_seq.sv
// Directed self-checking bench for lut_decoder_seq.
// A stand-in decoder packs its inputs into the lut_* buses so captured data is traceable.
module tb_lut_decoder_seq;

  localparam int WD    = 64;
  localparam int WC    = 16;
  localparam int LOG2N = 6;

  logic             clk = 1'b0;
  logic             srst, enable, start, mode;
  logic [1:0]       format;
  logic [LOG2N-1:0] n_last;
  logic             busy, done;
  logic [1:0]       d_x_n, d_y_n;
  logic             d_valid, d_ready;
  logic             dec_mode;
  logic [1:0]       dec_format;
  logic [LOG2N-1:0] dec_n;
  logic [1:0]       dec_d_x_n, dec_d_y_n;
  logic [2*WD-1:0]  lut_X_in, lut_Y_in, lut_X_q, lut_Y_q;
  logic [WC-1:0]    lut_u_in, lut_v_in, lut_u_q, lut_v_q;
  logic [LOG2N-1:0] lut_n_q;
  logic             lut_last, lut_valid, lut_ready, dig_err;

  int checks = 0;
  int errors = 0;

  lut_decoder_seq #(.WD(WD), .WC(WC), .LOG2N(LOG2N)) dut (
    .clk(clk), .srst(srst), .enable(enable), .start(start), .mode(mode), .format(format),
    .n_last(n_last), .busy(busy), .done(done), .d_x_n(d_x_n), .d_y_n(d_y_n),
    .d_valid(d_valid), .d_ready(d_ready), .dec_mode(dec_mode), .dec_format(dec_format),
    .dec_n(dec_n), .dec_d_x_n(dec_d_x_n), .dec_d_y_n(dec_d_y_n),
    .lut_X_in(lut_X_in), .lut_Y_in(lut_Y_in), .lut_u_in(lut_u_in), .lut_v_in(lut_v_in),
    .lut_X_q(lut_X_q), .lut_Y_q(lut_Y_q), .lut_u_q(lut_u_q), .lut_v_q(lut_v_q),
    .lut_n_q(lut_n_q), .lut_last(lut_last), .lut_valid(lut_valid), .lut_ready(lut_ready),
    .dig_err(dig_err)
  );

  always #5 clk = ~clk;

  assign lut_X_in = {{(2*WD-8){1'b0}}, dec_d_x_n, dec_n};
  assign lut_Y_in = {{(2*WD-8){1'b0}}, dec_d_y_n, dec_n};
  assign lut_u_in = {8'h5A, 2'b00, dec_n};
  assign lut_v_in = {dec_mode, dec_format, 7'b0, dec_n};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    srst = 1'b1; enable = 1'b1; start = 1'b0; mode = 1'b0; format = 2'b00; n_last = '0;
    d_x_n = 2'b00; d_y_n = 2'b00; d_valid = 1'b0; lut_ready = 1'b0;
    tick; tick;
    srst = 1'b0;
    checks++;
    if ({busy, done, d_ready, lut_valid, lut_last, dig_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000000",
               {busy, done, d_ready, lut_valid, lut_last, dig_err});
    end
    checks++;
    if ({dec_mode, dec_format, dec_n, dec_d_x_n, dec_d_y_n} !== '0) begin
      errors++;
      $display("FAIL reset_dec got=%h want=0", {dec_mode, dec_format, dec_n, dec_d_x_n, dec_d_y_n});
    end
    checks++;
    if ({lut_X_q, lut_Y_q, lut_u_q, lut_v_q, lut_n_q} !== '0) begin
      errors++;
      $display("FAIL reset_lut got=%h want=0", {lut_X_q, lut_Y_q, lut_u_q, lut_v_q, lut_n_q});
    end
  endtask

  // Full-throughput runs: n_last=3, n_last=0 (single) and n_last=63 (maximum count).
  task automatic test_basic_runs;
    int lasts[3] = '{3, 0, 63};
    int modes[3] = '{1, 0, 1};
    int fmts[3]  = '{2, 1, 3};
    for (int c = 0; c < 3; c++) begin
      int exp_n    = 0;
      int done_cyc = -1;
      logic [5:0] nl;
      logic m;
      logic [1:0] f;
      logic [2*WD+2*WD+2*WC-1:0] exp_d;
      nl = lasts[c][5:0];
      m  = modes[c][0];
      f  = fmts[c][1:0];
      n_last = nl; mode = m; format = f;
      d_x_n = 2'b01; d_y_n = 2'b11; d_valid = 1'b1; lut_ready = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if ({busy, d_ready, dec_mode, dec_format} !== {1'b1, 1'b1, m, f}) begin
        errors++;
        $display("FAIL run%0d_start got=%b want=%b", c, {busy, d_ready, dec_mode, dec_format},
                 {1'b1, 1'b1, m, f});
      end
      // cyc counts edges after the start edge; the start cycle itself is cycle 0.
      for (int cyc = 1; cyc <= 3 * 64 + 10 && done_cyc < 0; cyc++) begin
        if (lut_valid) begin
          exp_d = {{(2*WD-8){1'b0}}, 2'b01, exp_n[5:0], {(2*WD-8){1'b0}}, 2'b11, exp_n[5:0],
                   8'h5A, 2'b00, exp_n[5:0], m, f, 7'b0, exp_n[5:0]};
          checks++;
          if ({lut_n_q, lut_last} !== {exp_n[5:0], (exp_n[5:0] == nl)}) begin
            errors++;
            $display("FAIL run%0d_idx got n=%0d last=%b want n=%0d last=%b", c, lut_n_q,
                     lut_last, exp_n, (exp_n[5:0] == nl));
          end
          checks++;
          if ({lut_X_q, lut_Y_q, lut_u_q, lut_v_q} !== exp_d) begin
            errors++;
            $display("FAIL run%0d_data n=%0d got=%h want=%h", c, exp_n,
                     {lut_X_q, lut_Y_q, lut_u_q, lut_v_q}, exp_d);
          end
          checks++;
          if (cyc != 3 * exp_n + 3) begin
            errors++;
            $display("FAIL run%0d_valid_cycle got=%0d want=%0d", c, cyc, 3 * exp_n + 3);
          end
          exp_n++;
        end
        if (done) done_cyc = cyc;
        if (done_cyc < 0) tick;
      end
      // Inclusive of the start cycle the op spans 3N+2 cycles, so done lands 3N+1 edges later.
      checks++;
      if (done_cyc != 3 * (lasts[c] + 1) + 1) begin
        errors++;
        $display("FAIL run%0d_done_cycle got=%0d want=%0d", c, done_cyc, 3 * (lasts[c] + 1) + 1);
      end
      checks++;
      if (exp_n != lasts[c] + 1) begin
        errors++;
        $display("FAIL run%0d_valid_count got=%0d want=%0d", c, exp_n, lasts[c] + 1);
      end
      tick;
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL run%0d_idle got=%b want=00", c, {busy, done});
      end
    end
  endtask

  task automatic test_backpressure;
    int w = 0;
    logic [2*WD-1:0] exp_x;
    exp_x = {{(2*WD-8){1'b0}}, 2'b01, 6'd0};
    n_last = 6'd1; mode = 1'b0; format = 2'b00;
    d_x_n = 2'b01; d_y_n = 2'b11; d_valid = 1'b1; lut_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (!lut_valid && w < 10) begin tick; w++; end
    checks++;
    if (lut_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid_timeout got=%b want=1", lut_valid);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({lut_valid, d_ready, lut_n_q, dec_n, lut_X_q} !== {1'b1, 1'b0, 6'd0, 6'd0, exp_x}) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b n=%0d dn=%0d x=%h", k, lut_valid, d_ready,
                 lut_n_q, dec_n, lut_X_q);
      end
      tick;
    end
    lut_ready = 1'b1;
    tick;
    checks++;
    if ({d_ready, dec_n, lut_valid} !== {1'b1, 6'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_release got rdy=%b n=%0d v=%b want rdy=1 n=1 v=0", d_ready, dec_n,
               lut_valid);
    end
    w = 0;
    while (!done && w < 10) begin tick; w++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done_timeout got=%b want=1", done);
    end
    tick;
  endtask

  task automatic test_mid_reset;
    int w = 0;
    logic seen_done = 1'b0;
    logic seen_busy = 1'b0;
    n_last = 6'd3; mode = 1'b1; format = 2'b10;
    d_x_n = 2'b01; d_y_n = 2'b11; d_valid = 1'b1; lut_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    // LOOKUP is the only busy state with d_ready, lut_valid and done all low.
    while (!(busy && !d_ready && !lut_valid && !done && dec_n == 6'd2) && w < 20) begin
      tick; w++;
    end
    checks++;
    if (dec_n !== 6'd2 || d_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mr_reach_lookup got n=%0d rdy=%b busy=%b", dec_n, d_ready, busy);
    end
    srst = 1'b1;
    tick;
    srst = 1'b0;
    checks++;
    if ({busy, done, d_ready, lut_valid, lut_last, dig_err} !== 6'b0) begin
      errors++;
      $display("FAIL mr_flags got=%b want=000000",
               {busy, done, d_ready, lut_valid, lut_last, dig_err});
    end
    checks++;
    if ({dec_mode, dec_format, dec_n, dec_d_x_n, dec_d_y_n, lut_X_q, lut_Y_q, lut_u_q, lut_v_q,
         lut_n_q} !== '0) begin
      errors++;
      $display("FAIL mr_outputs got nonzero dec=%h n=%0d x=%h", {dec_mode, dec_format, dec_n},
               lut_n_q, lut_X_q);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    checks++;
    if ({seen_done, seen_busy} !== 2'b00) begin
      errors++;
      $display("FAIL mr_no_done got done=%b busy=%b want 0 0", seen_done, seen_busy);
    end
    n_last = 6'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    w = 0;
    while (!lut_valid && w < 10) begin tick; w++; end
    checks++;
    if ({lut_valid, lut_n_q} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL mr_restart got v=%b n=%0d want v=1 n=0", lut_valid, lut_n_q);
    end
    w = 0;
    while (!done && w < 10) begin tick; w++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL mr_done_timeout got=%b want=1", done);
    end
    tick;
  endtask

  task automatic test_enable;
    // Previous run left dec digits at (01,11).
    n_last = 6'd0; mode = 1'b0; format = 2'b01;
    d_valid = 1'b0; lut_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    enable = 1'b0; d_valid = 1'b1; d_x_n = 2'b11; d_y_n = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if ({d_ready, dec_d_x_n, dec_d_y_n} !== {1'b1, 2'b01, 2'b11}) begin
        errors++;
        $display("FAIL en_freeze%0d got rdy=%b dx=%b dy=%b want 1 01 11", k, d_ready,
                 dec_d_x_n, dec_d_y_n);
      end
    end
    enable = 1'b1;
    tick;
    checks++;
    if ({d_ready, dec_d_x_n, dec_d_y_n} !== {1'b0, 2'b11, 2'b01}) begin
      errors++;
      $display("FAIL en_accept got rdy=%b dx=%b dy=%b want 0 11 01", d_ready, dec_d_x_n,
               dec_d_y_n);
    end
    // Start while busy must not relatch n_last or mode.
    lut_ready = 1'b0; d_valid = 1'b0;
    start = 1'b1; n_last = 6'd5; mode = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if ({lut_valid, lut_last, dec_mode, lut_n_q} !== {1'b1, 1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL en_busy_start got v=%b last=%b mode=%b n=%0d want 1 1 0 0", lut_valid,
               lut_last, dec_mode, lut_n_q);
    end
    lut_ready = 1'b1; enable = 1'b0;
    tick; tick;
    checks++;
    if ({lut_valid, done} !== 2'b10) begin
      errors++;
      $display("FAIL en_hold_freeze got=%b want=10", {lut_valid, done});
    end
    enable = 1'b1;
    tick;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL en_done got=%b want=1", done);
    end
    enable = 1'b0;
    tick; tick;
    checks++;
    if ({done, busy} !== 2'b11) begin
      errors++;
      $display("FAIL en_done_stretch got=%b want=11", {done, busy});
    end
    enable = 1'b1;
    tick;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL en_done_end got=%b want=00", {done, busy});
    end
  endtask

  task automatic test_illegal_digit;
    int w = 0;
    logic [1:0] exp_dx;
    logic exp_err;
`ifdef LUT_SEQ_DIGIT_CHK_EN
    exp_dx = 2'b00; exp_err = 1'b1;
`else
    exp_dx = 2'b10; exp_err = 1'b0;
`endif
    n_last = 6'd0; mode = 1'b0; format = 2'b00;
    d_x_n = 2'b10; d_y_n = 2'b01; d_valid = 1'b1; lut_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    checks++;
    if ({dec_d_x_n, dec_d_y_n, dig_err} !== {exp_dx, 2'b01, exp_err}) begin
      errors++;
      $display("FAIL ill_lookup got dx=%b dy=%b err=%b want %b 01 %b", dec_d_x_n, dec_d_y_n,
               dig_err, exp_dx, exp_err);
    end
    tick;
    checks++;
    if ({lut_valid, lut_X_q[7:6]} !== {1'b1, exp_dx}) begin
      errors++;
      $display("FAIL ill_captured got v=%b dx=%b want 1 %b", lut_valid, lut_X_q[7:6], exp_dx);
    end
    lut_ready = 1'b1;
    tick; tick;
    checks++;
    if ({busy, dig_err} !== {1'b0, exp_err}) begin
      errors++;
      $display("FAIL ill_sticky got busy=%b err=%b want 0 %b", busy, dig_err, exp_err);
    end
    d_x_n = 2'b01;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (dig_err !== 1'b0) begin
      errors++;
      $display("FAIL ill_clear_on_start got=%b want=0", dig_err);
    end
    while (!done && w < 10) begin tick; w++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ill_done_timeout got=%b want=1", done);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic_runs;
    test_backpressure;
    test_mid_reset;
    test_enable;
    test_illegal_digit;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
